// File: rtl/niosballe_dbg_pkg.sv
// Shared types and jdo field positions for the Nios II debug monitor memory.
// Optional write-protect feature is enabled by defining NIOSBALLE_DEBUG_MEM_WP_EN.
package niosballe_dbg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRD  = 2'd1,
        CRD  = 2'd2
    } mon_state_t;

    localparam int JDO_ADDR_LSB  = 17;
    localparam int JDO_ADDR_MSB  = 25;
    localparam int JDO_RDFLAG    = 34;
    localparam int JDO_WDATA_LSB = 3;
    localparam int JDO_WP        = 36;

    // The jdo address field is 9 bits wide; a narrower RAM rejects the upper values.
    function automatic logic addr_fits(input logic [8:0] field, input int unsigned addr_w);
        return (addr_w >= 9) || ((field >> addr_w) == 9'd0);
    endfunction

endpackage

// File: rtl/niosballe_debug_mon_ram.sv
// Single-port synchronous monitor RAM: 32-bit words, byte enables, one-cycle read latency.
// Read-during-write returns the previous contents of the addressed word.
module niosballe_debug_mon_ram #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/niosballe_debug_mon_mem.sv
// Debug monitor memory: debug-side commands and a CPU Avalon-MM port sharing one RAM.
// Define NIOSBALLE_DEBUG_MEM_WP_EN to add a debugger-controlled CPU write-protect bit.
//
// state | meaning
// IDLE  | RAM port free; debug strobes first, then CPU write, then CPU read
// DRD   | debug read in flight; capture RAM data into MonDReg
// CRD   | CPU read in flight; return RAM data, RAM port free for a debug strobe
module niosballe_debug_mon_mem
    import niosballe_dbg_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest
);

    mon_state_t        state_q, state_d;
    logic [ADDR_W-1:0] mon_a_q, mon_a_d;
    logic [31:0]       mon_d_q, mon_d_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;
    logic              wr_done_q, wr_done_d;
    logic [31:0]       cpu_rdata_q;
    logic              wp_q;
    logic              wp_load;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    logic [8:0]        a_field;
    logic [31:0]       dbg_wdata;
    logic [ADDR_W-1:0] a_next;
    logic              any_strobe;
    logic              unused_jdo;

    assign a_field    = jdo[JDO_ADDR_MSB:JDO_ADDR_LSB];
    assign dbg_wdata  = jdo[JDO_RDFLAG:JDO_WDATA_LSB];
    assign a_next     = mon_a_q + ADDR_W'(1);
    assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

    always_comb begin
        state_d         = state_q;
        mon_a_d         = mon_a_q;
        mon_d_d         = mon_d_q;
        ready_d         = ready_q;
        error_d         = error_q;
        wr_done_d       = wr_done_q;
        wp_load         = 1'b0;
        ram_addr        = mon_a_q;
        ram_we          = 1'b0;
        ram_be          = 4'hF;
        ram_wdata       = dbg_wdata;
        avs_waitrequest = 1'b0;

        if (state_q == DRD) begin
            mon_d_d         = ram_rdata;
            ready_d         = 1'b1;
            state_d         = IDLE;
            avs_waitrequest = avs_read | avs_write;
            if (any_strobe) error_d = 1'b1;
        end else begin
            if (state_q == CRD) begin
                state_d   = IDLE;
                wr_done_d = 1'b0;
            end

            if (take_action_ocimem_b) begin
                ram_we  = 1'b1;
                mon_d_d = dbg_wdata;
                mon_a_d = a_next;
                ready_d = 1'b1;
                error_d = 1'b0;
            end else if (take_action_ocimem_a) begin
                ready_d = 1'b1;
                if (!addr_fits(a_field, ADDR_W)) begin
                    error_d = 1'b1;
                end else begin
                    mon_a_d = a_field[ADDR_W-1:0];
                    error_d = 1'b0;
                    wp_load = 1'b1;
                    if (jdo[JDO_RDFLAG]) begin
                        ram_addr = a_field[ADDR_W-1:0];
                        state_d  = DRD;
                        ready_d  = 1'b0;
                    end
                end
            end else if (take_no_action_ocimem_a) begin
                mon_a_d  = a_next;
                ram_addr = a_next;
                state_d  = DRD;
                ready_d  = 1'b0;
                error_d  = 1'b0;
            end

            // CPU only gets the port in IDLE; in CRD its read completes instead.
            if (state_q == IDLE) begin
                if (any_strobe) begin
                    avs_waitrequest = avs_read | avs_write;
                end else if (avs_write && !wr_done_q) begin
                    ram_we    = !wp_q;
                    ram_be    = avs_byteenable;
                    ram_addr  = avs_address;
                    ram_wdata = avs_writedata;
                    if (avs_read) begin
                        avs_waitrequest = 1'b1;
                        wr_done_d       = 1'b1;
                    end
                end else if (avs_read) begin
                    ram_addr        = avs_address;
                    avs_waitrequest = 1'b1;
                    state_d         = CRD;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            mon_a_q     <= '0;
            mon_d_q     <= '0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
            wr_done_q   <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            mon_a_q   <= mon_a_d;
            mon_d_q   <= mon_d_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
            wr_done_q <= wr_done_d;
            if (state_q == CRD) cpu_rdata_q <= ram_rdata;
        end
    end

`ifdef NIOSBALLE_DEBUG_MEM_WP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp_q <= 1'b0;
        end else if (wp_load) begin
            wp_q <= jdo[JDO_WP];
        end
    end
`else
    logic unused_wp;
    assign wp_q      = 1'b0;
    assign unused_wp = wp_load ^ jdo[JDO_WP];
`endif

    assign MonDReg       = mon_d_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;
    assign avs_readdata  = (state_q == CRD) ? ram_rdata : cpu_rdata_q;

    niosballe_debug_mon_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .be    (ram_be),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_niosballe_debug_mon_mem.sv
// Self-checking bench for niosballe_debug_mon_mem (ADDR_W=8): directed table, corner sequences, random vs. model.
// Write-protect checks are included when NIOSBALLE_DEBUG_MEM_WP_EN is defined.
module tb_niosballe_debug_mon_mem;

    localparam int K_A  = 0;
    localparam int K_NA = 1;
    localparam int K_B  = 2;

    logic        clk;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_a, take_na, take_b;
    logic [31:0] mon_d;
    logic        mon_rdy, mon_err;
    logic [7:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;

    int total = 0;
    int bad   = 0;

    // Reference model: plain memory array plus the debugger-visible registers.
    logic [31:0] ram_m [256];
    int          m_mona;
    logic [31:0] m_mond;
    bit          m_rdy, m_err, m_wp;

    typedef struct {
        int          kind;
        logic [8:0]  field;
        bit          rd;
        logic [31:0] data;
        bit          r1, e1, r2, e2;
        logic [31:0] mond;
    } vec_t;

    vec_t vt [10];

    niosballe_debug_mon_mem #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_no_action_ocimem_a (take_na),
        .take_action_ocimem_b    (take_b),
        .MonDReg                 (mon_d),
        .monitor_ready           (mon_rdy),
        .monitor_error           (mon_err),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] mk_jdo(input int kind, input logic [8:0] field, input bit rd,
                                           input bit wp, input logic [31:0] data);
        logic [37:0] j;
        j = 38'({$urandom(), $urandom()});
        if (kind == K_B) begin
            j[34:3] = data;
        end else if (kind == K_A) begin
            j[25:17] = field;
            j[34]    = rd;
            j[36]    = wp;
        end
        return j;
    endfunction

    task automatic m_dbg(input int kind, input logic [37:0] j);
        int f;
        case (kind)
            K_B: begin
                ram_m[m_mona] = j[34:3];
                m_mond        = j[34:3];
                m_mona        = (m_mona + 1) % 256;
                m_err         = 1'b0;
            end
            K_NA: begin
                m_mona = (m_mona + 1) % 256;
                m_mond = ram_m[m_mona];
                m_err  = 1'b0;
            end
            default: begin
                f = int'(j[25:17]);
                if (f >= 256) begin
                    m_err = 1'b1;
                end else begin
                    m_mona = f;
                    m_err  = 1'b0;
                    m_wp   = j[36];
                    if (j[34]) m_mond = ram_m[f];
                end
            end
        endcase
        m_rdy = 1'b1;
    endtask

    task automatic m_cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
`ifdef NIOSBALLE_DEBUG_MEM_WP_EN
        if (m_wp) return;
`endif
        for (int b = 0; b < 4; b++) begin
            if (be[b]) ram_m[a][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic m_reset();
        m_mona = 0;
        m_mond = '0;
        m_rdy  = 1'b0;
        m_err  = 1'b0;
        m_wp   = 1'b0;
    endtask

    task automatic dbg(input int kind, input logic [37:0] j);
        jdo = j;
        case (kind)
            K_A:     take_a  = 1'b1;
            K_NA:    take_na = 1'b1;
            default: take_b  = 1'b1;
        endcase
        tick();
        take_a  = 1'b0;
        take_na = 1'b0;
        take_b  = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be, output int waits);
        avs_address    = a;
        avs_writedata  = d;
        avs_byteenable = be;
        avs_write      = 1'b1;
        waits          = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!avs_waitrequest) break;
            waits++;
            tick();
        end
        tick();
        avs_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a, output logic [31:0] d, output int waits);
        avs_address = a;
        avs_read    = 1'b1;
        waits       = 0;
        d           = 32'hDEAD_DEAD;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!avs_waitrequest) begin
                d = avs_readdata;
                break;
            end
            waits++;
            tick();
        end
        tick();
        avs_read = 1'b0;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_mond"}, mon_d, m_mond);
        chk({tag, "_rdy"}, 32'(mon_rdy), 32'(m_rdy));
        chk({tag, "_err"}, 32'(mon_err), 32'(m_err));
    endtask

    initial begin
        logic [37:0] j;
        logic [31:0] d;
        int          w, wsum;
        int          op;
        logic [7:0]  a;

        reset_n        = 1'b0;
        jdo            = '0;
        take_a         = 1'b0;
        take_na        = 1'b0;
        take_b         = 1'b0;
        avs_address    = '0;
        avs_read       = 1'b0;
        avs_write      = 1'b0;
        avs_writedata  = '0;
        avs_byteenable = 4'hF;
        m_reset();

        //             kind   field    rd  data          r1 e1 r2 e2 mond
        vt[0] = '{K_A,  9'd5,   1, 32'h0,         0, 0, 1, 0, 32'h12345678};
        vt[1] = '{K_NA, 9'd0,   0, 32'h0,         0, 0, 1, 0, 32'hCAFEF00D};
        vt[2] = '{K_A,  9'd256, 1, 32'h0,         1, 1, 1, 1, 32'hCAFEF00D};
        vt[3] = '{K_B,  9'd0,   0, 32'h0BADBEEF,  1, 0, 1, 0, 32'h0BADBEEF};
        vt[4] = '{K_A,  9'd6,   1, 32'h0,         0, 0, 1, 0, 32'h0BADBEEF};
        vt[5] = '{K_A,  9'd255, 0, 32'h0,         1, 0, 1, 0, 32'h0BADBEEF};
        vt[6] = '{K_B,  9'd0,   0, 32'hA5A5A5A5,  1, 0, 1, 0, 32'hA5A5A5A5};
        vt[7] = '{K_B,  9'd0,   0, 32'hA5A5A5A5,  1, 0, 1, 0, 32'hA5A5A5A5};
        vt[8] = '{K_NA, 9'd0,   0, 32'h0,         0, 0, 1, 0, 32'h22222222};
        vt[9] = '{K_A,  9'h1FF, 1, 32'h0,         1, 1, 1, 1, 32'h22222222};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mond", mon_d, 32'h0);
        chk("rst_rdy", 32'(mon_rdy), 32'h0);
        chk("rst_err", 32'(mon_err), 32'h0);
        chk("rst_rdata", avs_readdata, 32'h0);
        chk("rst_wait", 32'(avs_waitrequest), 32'h0);
        reset_n = 1'b1;
        tick();
        chk("post_rst_rdy", 32'(mon_rdy), 32'h0);

        // Fill RAM through the CPU port so every word is known.
        for (int i = 0; i < 256; i++) ram_m[i] = $urandom();
        ram_m[2] = 32'h22222222;
        ram_m[3] = 32'h03030303;
        ram_m[5] = 32'h12345678;
        ram_m[6] = 32'hCAFEF00D;
        wsum = 0;
        for (int i = 0; i < 256; i++) begin
            cpu_write(8'(i), ram_m[i], 4'hF, w);
            wsum += w;
        end
        chk("fill_wait_states", 32'(wsum), 32'h0);

        for (int i = 0; i < 10; i++) begin
            j = mk_jdo(vt[i].kind, vt[i].field, vt[i].rd, 1'b0, vt[i].data);
            dbg(vt[i].kind, j);
            m_dbg(vt[i].kind, j);
            #1;
            chk($sformatf("vec%0d_rdy_t1", i), 32'(mon_rdy), 32'(vt[i].r1));
            chk($sformatf("vec%0d_err_t1", i), 32'(mon_err), 32'(vt[i].e1));
            tick();
            chk($sformatf("vec%0d_rdy_t2", i), 32'(mon_rdy), 32'(vt[i].r2));
            chk($sformatf("vec%0d_err_t2", i), 32'(mon_err), 32'(vt[i].e2));
            chk($sformatf("vec%0d_mond", i), mon_d, vt[i].mond);
        end

        cpu_read(8'd255, d, w);
        chk("wrap_ram255", d, 32'hA5A5A5A5);
        chk("cpu_read_waits", 32'(w), 32'h1);
        cpu_read(8'd0, d, w);
        chk("wrap_ram0", d, 32'hA5A5A5A5);

        // Reset during a debug read abandons it; RAM keeps its contents.
        j = mk_jdo(K_A, 9'd6, 1'b1, 1'b0, 32'h0);
        dbg(K_A, j);
        reset_n = 1'b0;
        #1;
        chk("midrst_mond", mon_d, 32'h0);
        chk("midrst_rdy", 32'(mon_rdy), 32'h0);
        chk("midrst_err", 32'(mon_err), 32'h0);
        tick();
        reset_n = 1'b1;
        m_reset();
        tick();
        j = mk_jdo(K_A, 9'd5, 1'b1, 1'b0, 32'h0);
        dbg(K_A, j);
        m_dbg(K_A, j);
        tick();
        chk_model("after_rst");

        // CPU read held across a debug read strobe.
        avs_address = 8'd200;
        avs_read    = 1'b1;
        jdo         = mk_jdo(K_A, 9'd77, 1'b1, 1'b0, 32'h0);
        take_a      = 1'b1;
        #1;
        chk("cont_wait_t", 32'(avs_waitrequest), 32'h1);
        @(posedge clk);
        #1;
        take_a = 1'b0;
        m_dbg(K_A, jdo);
        #1;
        chk("cont_wait_drd", 32'(avs_waitrequest), 32'h1);
        chk("cont_rdy_t1", 32'(mon_rdy), 32'h0);
        tick();
        chk_model("cont_dbg");
        cpu_read(8'd200, d, w);
        chk("cont_cpu_data", d, ram_m[200]);

        // Strobe arriving while the debug read is in flight is dropped.
        j = mk_jdo(K_NA, 9'd0, 1'b0, 1'b0, 32'h0);
        dbg(K_NA, j);
        m_dbg(K_NA, j);
        jdo    = mk_jdo(K_B, 9'd0, 1'b0, 1'b0, ~ram_m[m_mona]);
        take_b = 1'b1;
        tick();
        take_b = 1'b0;
        m_err  = 1'b1;
        chk_model("overrun");
        chk("overrun_err_set", 32'(mon_err), 32'h1);
        cpu_read(8'(m_mona), d, w);
        chk("overrun_ram_kept", d, ram_m[m_mona]);

        // Debug strobe accepted in the CPU read-return cycle.
        avs_address = 8'd9;
        avs_read    = 1'b1;
        #1;
        chk("crd_wait_issue", 32'(avs_waitrequest), 32'h1);
        tick();
        jdo    = mk_jdo(K_A, 9'd40, 1'b1, 1'b0, 32'h0);
        take_a = 1'b1;
        #1;
        chk("crd_wait_low", 32'(avs_waitrequest), 32'h0);
        chk("crd_cpu_data", avs_readdata, ram_m[9]);
        @(posedge clk);
        #1;
        take_a   = 1'b0;
        avs_read = 1'b0;
        m_dbg(K_A, jdo);
        chk("crd_dbg_rdy_t1", 32'(mon_rdy), 32'h0);
        tick();
        chk_model("crd_dbg");

        // Simultaneous strobes: the write wins.
        j       = mk_jdo(K_B, 9'd0, 1'b0, 1'b0, 32'h600DF00D);
        jdo     = j;
        take_a  = 1'b1;
        take_na = 1'b1;
        take_b  = 1'b1;
        tick();
        take_a  = 1'b0;
        take_na = 1'b0;
        take_b  = 1'b0;
        m_dbg(K_B, j);
        chk_model("prio_t1");
        tick();
        chk_model("prio_t2");

        // Read and write together: the write lands before the read returns.
        avs_address    = 8'd17;
        avs_writedata  = 32'h5A5AC3C3;
        avs_byteenable = 4'b0101;
        avs_write      = 1'b1;
        avs_read       = 1'b1;
        d              = 32'hDEAD_DEAD;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!avs_waitrequest) begin
                d = avs_readdata;
                break;
            end
            tick();
        end
        tick();
        avs_write = 1'b0;
        avs_read  = 1'b0;
        m_cpu_write(8'd17, 32'h5A5AC3C3, 4'b0101);
        chk("rw_both_data", d, ram_m[17]);

`ifdef NIOSBALLE_DEBUG_MEM_WP_EN
        j = mk_jdo(K_A, 9'd3, 1'b0, 1'b1, 32'h0);
        dbg(K_A, j);
        m_dbg(K_A, j);
        tick();
        cpu_write(8'd3, 32'hFFFFFFFF, 4'hF, w);
        chk("wp_wait_states", 32'(w), 32'h0);
        m_cpu_write(8'd3, 32'hFFFFFFFF, 4'hF);
        cpu_read(8'd3, d, w);
        chk("wp_ram_unchanged", d, 32'h03030303);
        j = mk_jdo(K_B, 9'd0, 1'b0, 1'b0, 32'h13572468);
        dbg(K_B, j);
        m_dbg(K_B, j);
        tick();
        cpu_read(8'd3, d, w);
        chk("wp_dbg_write", d, 32'h13572468);
        j = mk_jdo(K_A, 9'd0, 1'b0, 1'b0, 32'h0);
        dbg(K_A, j);
        m_dbg(K_A, j);
        tick();
`endif

        // Random mix of uncontended operations against the model.
        for (int n = 0; n < 400; n++) begin
            op = int'($urandom_range(0, 5));
            case (op)
                0: begin
                    j = mk_jdo(K_A, 9'($urandom_range(0, 300)), 1'($urandom()), 1'($urandom()), 32'h0);
                    dbg(K_A, j);
                    m_dbg(K_A, j);
                    tick();
                    chk_model("rnd_a");
                end
                1: begin
                    j = mk_jdo(K_NA, 9'd0, 1'b0, 1'b0, 32'h0);
                    dbg(K_NA, j);
                    m_dbg(K_NA, j);
                    tick();
                    chk_model("rnd_na");
                end
                2: begin
                    j = mk_jdo(K_B, 9'd0, 1'b0, 1'b0, $urandom());
                    dbg(K_B, j);
                    m_dbg(K_B, j);
                    tick();
                    chk_model("rnd_b");
                end
                3: begin
                    a = 8'($urandom());
                    d = $urandom();
                    op = int'($urandom_range(0, 15));
                    cpu_write(a, d, 4'(op), w);
                    m_cpu_write(a, d, 4'(op));
                    chk("rnd_wr_waits", 32'(w), 32'h0);
                end
                default: begin
                    a = 8'($urandom());
                    cpu_read(a, d, w);
                    chk("rnd_rd_data", d, ram_m[a]);
                    chk("rnd_rd_waits", 32'(w), 32'h1);
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/niosballe_debug_mon_mem.md
# niosballe_debug_mon_mem

Debug monitor memory for the Nios II debug slave, on the system-clock side, directly downstream of the JTAG debug slave wrapper. It consumes the wrapper's `jdo` word and `take_*_ocimem_*` strobes to read and write a private on-chip monitor RAM. It returns `MonDReg`, `monitor_ready` and `monitor_error` to the wrapper for scan-out. The CPU reaches the same RAM through a small Avalon-MM slave port; debug accesses have priority.

## Interface
- `ADDR_W`, 8, RAM word-address width (1..9); depth = 2^ADDR_W 32-bit words.
- `clk`  in  1  system clock (wrapper `clk`)
- `reset_n`  in  1  reset; one clock, asynchronous, active-low
- `jdo`  in  38  debug data word from wrapper
- `take_action_ocimem_a`  in  1  set-address (optional read) strobe, 1 cycle
- `take_no_action_ocimem_a`  in  1  read-next strobe, 1 cycle
- `take_action_ocimem_b`  in  1  write-and-increment strobe, 1 cycle
- `MonDReg`  out  32  monitor data register
- `monitor_ready`  out  1  last debug command complete
- `monitor_error`  out  1  last debug command rejected
- `avs_address`  in  ADDR_W  CPU word address
- `avs_read`, `avs_write`  in  1  CPU access requests
- `avs_writedata`  in  32  CPU write data
- `avs_byteenable`  in  4  CPU byte lanes
- `avs_readdata`  out  32  CPU read data
- `avs_waitrequest`  out  1  CPU stall

## Operation
- Registers:
  - `MonAReg[ADDR_W-1:0]`: debug address pointer.
  - `MonDReg`: monitor data register.
  - FSM states: `IDLE`, `DRD` (debug read in flight), `CRD` (CPU read in flight).
- Debug commands. At most one strobe per cycle is expected; if several arrive together, priority is `ocimem_b` > `ocimem_a` > `no_action_ocimem_a`.
  - **ocimem_a**
    - Address field `jdo[25:17]`. If it is ≥ 2^ADDR_W: `monitor_error`=1, `MonAReg` unchanged, no RAM access.
    - Otherwise: `MonAReg` ← field.
    - If `jdo[34]`=1, issue a RAM read at the field address and go to `DRD`.
  - **no_action_ocimem_a**: `MonAReg` ← `MonAReg`+1, wrapping from 2^ADDR_W−1 to 0; issue a RAM read at the incremented address; go to `DRD`.
  - **ocimem_b**: write `jdo[34:3]` (all four bytes) to RAM[`MonAReg`]; `MonDReg` ← `jdo[34:3]`; `MonAReg` ← `MonAReg`+1, wrapping.
  - `DRD`: capture RAM read data into `MonDReg`, return to `IDLE`.
  - Any accepted error-free command clears `monitor_error`.
  - A strobe arriving while in `DRD` is dropped and sets `monitor_error`=1. The in-flight read still completes normally.
- CPU port:
  - A read in `IDLE` with no debug strobe issues the RAM read, asserts `avs_waitrequest` and goes to `CRD`.
  - `CRD`: drive `avs_readdata`, deassert `avs_waitrequest`, return to `IDLE`.
  - A write in `IDLE` with no debug strobe completes in one cycle using byte enables.
  - A CPU request coinciding with a debug strobe, or arriving in `DRD`, sees `avs_waitrequest`=1 and is retried by the master.
  - A debug strobe arriving in `CRD` is accepted, since the RAM port is free that cycle.
  - `avs_read` and `avs_write` asserted together: the write is served first.

## Timing
- Reset values:
  - `MonAReg`=0, `MonDReg`=0, FSM=`IDLE`.
  - `monitor_ready`=0, `monitor_error`=0.
  - `avs_readdata`=0, `avs_waitrequest`=0.
- Let T be the strobe cycle.
- Debug read:
  - `monitor_ready` is 0 at T+1.
  - `MonDReg` is valid and `monitor_ready`=1 at T+2.
- Debug write, address-only command, or error: `monitor_ready`=1 at T+1.
- `monitor_ready` stays 1 until the next accepted strobe.
- CPU read: `avs_waitrequest` high for exactly 1 cycle when uncontended; `avs_readdata` is valid in the cycle `avs_waitrequest` falls.
- CPU write: zero wait states when uncontended.
- Reset asserted mid-operation: the access is abandoned, all registers go to their reset values, and RAM contents are undefined-but-stable.

## Configuration
- `NIOSBALLE_DEBUG_MEM_WP_EN` defined:
  - ocimem_a loads a write-protect bit from `jdo[36]`; the bit resets to 0.
  - While it is set, CPU writes complete with zero wait states but do not modify the RAM.
  - Debug writes are never blocked.
- Undefined: `jdo[36]` is ignored and CPU writes always take effect.

## Structure
- Package `niosballe_dbg_pkg` holds:
  - the FSM state enum;
  - `jdo` field constants: `JDO_ADDR_LSB`=17, `JDO_ADDR_MSB`=25, `JDO_RDFLAG`=34, `JDO_WDATA_LSB`=3, `JDO_WP`=36.
- One sub-module, `niosballe_debug_mon_ram`: single-port synchronous RAM with 32-bit data, byte enables and 1-cycle read latency.

## Test plan
- Set address and read: write RAM[5]=0x12345678 via CPU, then ocimem_a with `jdo[25:17]`=5 and `jdo[34]`=1 → at T+2 `MonDReg`=0x12345678, `monitor_ready`=1.
- Write burst with wrap: ocimem_a addr=255 (ADDR_W=8), then ocimem_b with 0xA5A5A5A5 twice → RAM[255] and RAM[0] hold the data, `MonAReg`=1; CPU reads of both return 0xA5A5A5A5.
- Out of range: ocimem_a addr=256 with ADDR_W=8 → `monitor_error`=1, `monitor_ready`=1 at T+1, `MonAReg` unchanged; a following valid command clears the error.
- Contention: CPU read held on the cycle of a debug read strobe → `avs_waitrequest` stays high through `DRD`; CPU read data is returned afterwards; the debug read is correct.
- Overrun: no_action_ocimem_a at T and ocimem_b at T+1 → the write is dropped, `monitor_error`=1, and `MonDReg` holds the read data.
- Write protect (macro on): ocimem_a with `jdo[36]`=1, then CPU write 0xFFFFFFFF to addr 3 → RAM[3] unchanged; the CPU write shows no wait state.
